// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_pkg: shared state encoding and default parameters for the
// FIFO-fed UART transmitter. FIFO_UART_TX_PARITY_EN adds the PARITY state.
package fifo_uart_pkg;

  localparam int DSIZE_DEF        = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_START  = 3'd1;
  localparam logic [2:0] ENC_DATA   = 3'd2;
  localparam logic [2:0] ENC_PARITY = 3'd3;
  localparam logic [2:0] ENC_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ENC_IDLE,
    START  = ENC_START,
    DATA   = ENC_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = ENC_PARITY,
`endif
    STOP   = ENC_STOP
  } tx_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read port plus serial-side signals of the transmitter.
// slave = transmitter side, master = FIFO/system side.
interface fifo_uart_tx_if
  import fifo_uart_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
);

  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic             tx_en;
  logic             tx;
  logic             busy;
  logic             frame_done;

  modport slave (
    input  rdata,
    input  rempty,
    input  tx_en,
    output rinc,
    output tx,
    output busy,
    output frame_done
  );

  modport master (
    output rdata,
    output rempty,
    output tx_en,
    input  rinc,
    input  tx,
    input  busy,
    input  frame_done
  );

endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// uart_baud_gen: counts clk cycles within one serial bit. bit_end marks the
// last cycle of the bit; the counter returns to 0 at every bit boundary and
// is held at 0 while restart is high.
module uart_baud_gen
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at the bit boundary, hold at zero on restart.
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    bit_end = (cnt_q == CNT_LAST);
    if (restart || bit_end) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a show-ahead FIFO and sends them as
// 8N1-style frames (start, DSIZE data bits LSB first, stop).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit after the data.
//
// state  | meaning
// IDLE   | line high, waiting for tx_en=1 and rempty=0
// START  | start bit (tx=0)
// DATA   | data bits, LSB first, bit_idx counts them
// PARITY | even parity of the word (only with FIFO_UART_TX_PARITY_EN)
// STOP   | stop bit (tx=1); may pop the next word in its last cycle
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DSIZE        = DSIZE_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_uart_tx_if.slave         bus
);

  localparam int IW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DSIZE - 1);

  tx_state_e        state_q, state_d;
  logic [DSIZE-1:0] sh_q, sh_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             rinc_q, rinc_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic restart;
  logic bit_end;
  logic pop_ok;
  logic load;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .bit_end (bit_end)
  );

  // Next-state, shift register, bit index and pop decision.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    rinc_d  = 1'b0;
    restart = 1'b0;
    load    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    pop_ok  = bus.tx_en && !bus.rempty;

    case (state_q)
      IDLE: begin
        // Keep the baud counter at zero so START gets a full bit.
        restart = 1'b1;
        tx_d    = 1'b1;
        load    = pop_ok;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (pop_ok) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Pop: capture the head word, strobe rinc once and begin the start bit.
    if (load) begin
      state_d = START;
      sh_d    = bus.rdata;
      idx_d   = '0;
      tx_d    = 1'b0;
      rinc_d  = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      par_d   = ^bus.rdata;
`endif
    end
  end

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      rinc_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      rinc_q  <= rinc_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.tx         = tx_q;
  assign bus.rinc       = rinc_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with DSIZE=8,
// CLKS_PER_BIT=4 and a 16-deep show-ahead FIFO model.
module tb_fifo_uart_tx;

  localparam int DSIZE = 8;
  localparam int CPB   = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = DSIZE + 3;
`else
  localparam int NB = DSIZE + 2;
`endif
  localparam int FLEN  = NB * CPB;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;

  fifo_uart_tx_if #(.DSIZE(DSIZE)) bus ();

  fifo_uart_tx #(.DSIZE(DSIZE), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int rinc_cnt = 0;
  logic [DSIZE-1:0] fifo_q[$];
  logic wfull;

  task automatic fifo_refresh();
    bus.rempty = (fifo_q.size() == 0);
    bus.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    wfull      = (fifo_q.size() == DEPTH);
  endtask

  task automatic push_word(input logic [DSIZE-1:0] w);
    if (fifo_q.size() < DEPTH) fifo_q.push_back(w);
    fifo_refresh();
  endtask

  task automatic fifo_flush();
    fifo_q.delete();
    fifo_refresh();
  endtask

  // FIFO model pops mid-cycle while rinc is high, away from the DUT's edge.
  always @(negedge clk) begin
    if (bus.rinc === 1'b1) begin
      rinc_cnt++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      fifo_refresh();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a pop, then checks every cycle of the resulting frame.
  task automatic frame_check(input logic [DSIZE-1:0] w, input int drop_at,
                             input bit b2b, input string nm);
    logic exp_bits [NB];
    int waited = 0;
    do begin
      tick();
      waited++;
    end while (bus.rinc !== 1'b1 && waited < 300);
    vectors++;
    if (bus.rinc !== 1'b1) begin
      $display("FAIL %s rinc_timeout got %b exp 1", nm, bus.rinc);
      errors++;
      return;
    end
    if (b2b) begin
      vectors++;
      if (waited != 1) begin
        $display("FAIL %s b2b_gap got %0d cycles exp %0d", nm, FLEN + waited - 1, FLEN);
        errors++;
      end
    end
    exp_bits[0] = 1'b0;
    for (int i = 0; i < DSIZE; i++) exp_bits[1+i] = w[i];
`ifdef FIFO_UART_TX_PARITY_EN
    exp_bits[DSIZE+1] = ^w;
`endif
    exp_bits[NB-1] = 1'b1;
    for (int c = 1; c <= FLEN; c++) begin
      if (c > 1) tick();
      if (c == drop_at) bus.tx_en = 1'b0;
      vectors += 4;
      if (bus.tx !== exp_bits[(c-1)/CPB]) begin
        $display("FAIL %s tx cyc %0d got %b exp %b", nm, c, bus.tx, exp_bits[(c-1)/CPB]);
        errors++;
      end
      if (bus.frame_done !== (c == FLEN)) begin
        $display("FAIL %s frame_done cyc %0d got %b exp %b", nm, c, bus.frame_done, (c == FLEN));
        errors++;
      end
      if (bus.busy !== 1'b1) begin
        $display("FAIL %s busy cyc %0d got %b exp 1", nm, c, bus.busy);
        errors++;
      end
      if (bus.rinc !== (c == 1)) begin
        $display("FAIL %s rinc cyc %0d got %b exp %b", nm, c, bus.rinc, (c == 1));
        errors++;
      end
    end
  endtask

  task automatic check_idle(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      tick();
      vectors++;
      if (bus.rinc !== 1'b0 || bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
        $display("FAIL %s idle cyc %0d got rinc=%b tx=%b busy=%b exp rinc=0 tx=1 busy=0",
                 nm, i, bus.rinc, bus.tx, bus.busy);
        errors++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.tx_en = 1'b0;
    fifo_flush();
    repeat (3) tick();
    vectors++;
    if (bus.tx !== 1'b1 || bus.rinc !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
      $display("FAIL reset_outputs got tx=%b rinc=%b busy=%b fd=%b exp 1 0 0 0",
               bus.tx, bus.rinc, bus.busy, bus.frame_done);
      errors++;
    end
    #2 rst_n = 1'b1;
    check_idle(3, "post_reset");
  endtask

  task automatic test_single_word();
    rinc_cnt = 0;
    push_word(8'hA5);
    bus.tx_en = 1'b1;
    frame_check(8'hA5, 0, 1'b0, "single_A5");
    check_idle(10, "single_after");
    vectors++;
    if (rinc_cnt != 1) begin
      $display("FAIL single_rinc_count got %0d exp 1", rinc_cnt);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    bus.tx_en = 1'b0;
    rinc_cnt = 0;
    push_word(8'h01);
    push_word(8'h80);
    push_word(8'hFF);
    tick();
    bus.tx_en = 1'b1;
    frame_check(8'h01, 0, 1'b0, "b2b_01");
    frame_check(8'h80, 0, 1'b1, "b2b_80");
    frame_check(8'hFF, 0, 1'b1, "b2b_FF");
    check_idle(10, "b2b_after");
    vectors++;
    if (rinc_cnt != 3) begin
      $display("FAIL b2b_rinc_count got %0d exp 3", rinc_cnt);
      errors++;
    end
  endtask

  task automatic test_empty_gating();
    bus.tx_en = 1'b1;
    check_idle(100, "empty");
    bus.tx_en = 1'b0;
    push_word(8'h5A);
    check_idle(20, "gated");
    push_word(8'hC3);
    bus.tx_en = 1'b1;
    frame_check(8'h5A, 10, 1'b0, "drop_en_5A");
    check_idle(60, "drop_en_after");
    vectors++;
    if (fifo_q.size() != 1) begin
      $display("FAIL drop_en_fifo_level got %0d exp 1", fifo_q.size());
      errors++;
    end
    fifo_flush();
  endtask

  task automatic test_reset_mid_frame();
    int waited = 0;
    bus.tx_en = 1'b0;
    push_word(8'h55);
    push_word(8'h3C);
    bus.tx_en = 1'b1;
    do begin
      tick();
      waited++;
    end while (bus.rinc !== 1'b1 && waited < 50);
    vectors++;
    if (bus.rinc !== 1'b1) begin
      $display("FAIL rst_mid_rinc_timeout got %b exp 1", bus.rinc);
      errors++;
    end
    repeat (17) tick();
    vectors++;
    if (bus.tx !== 1'b0 || bus.busy !== 1'b1) begin
      $display("FAIL rst_mid_bit3 got tx=%b busy=%b exp tx=0 busy=1", bus.tx, bus.busy);
      errors++;
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.rinc !== 1'b0 || bus.frame_done !== 1'b0) begin
      $display("FAIL rst_mid_async got tx=%b busy=%b rinc=%b fd=%b exp 1 0 0 0",
               bus.tx, bus.busy, bus.rinc, bus.frame_done);
      errors++;
    end
    repeat (2) tick();
    vectors++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
      $display("FAIL rst_mid_held got tx=%b busy=%b exp tx=1 busy=0", bus.tx, bus.busy);
      errors++;
    end
    #1 rst_n = 1'b1;
    frame_check(8'h3C, 0, 1'b0, "rst_mid_next_3C");
    check_idle(10, "rst_mid_after");
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    bus.tx_en = 1'b0;
    push_word(8'h07);
    push_word(8'h03);
    bus.tx_en = 1'b1;
    frame_check(8'h07, 0, 1'b0, "parity_07");
    frame_check(8'h03, 0, 1'b1, "parity_03");
    check_idle(10, "parity_after");
  endtask
`endif

  task automatic test_fifo_end_to_end();
    bus.tx_en = 1'b0;
    rinc_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (wfull !== 1'b0) begin
        $display("FAIL e2e_wfull_early word %0d got %b exp 0", i, wfull);
        errors++;
      end
      push_word(DSIZE'(i));
    end
    vectors++;
    if (wfull !== 1'b1) begin
      $display("FAIL e2e_wfull got %b exp 1", wfull);
      errors++;
    end
    bus.tx_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      frame_check(DSIZE'(i), 0, (i > 0), $sformatf("e2e_word_%0d", i));
    end
    vectors++;
    if (bus.rempty !== 1'b1) begin
      $display("FAIL e2e_rempty got %b exp 1", bus.rempty);
      errors++;
    end
    check_idle(60, "e2e_after");
    vectors++;
    if (rinc_cnt != DEPTH) begin
      $display("FAIL e2e_rinc_count got %0d exp %0d", rinc_cnt, DEPTH);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_empty_gating();
    test_reset_mid_frame();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    test_fifo_end_to_end();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DSIZE, default 8, SHALL set the data word width popped from the FIFO and serialized.
REQ-002 Parameter CLKS_PER_BIT, default 16, legal range 2..65535, SHALL set the clk cycles per serial bit.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rdata  input  DSIZE  show-ahead FIFO head word, valid whenever rempty=0.
REQ-006 rempty  input  1  FIFO empty flag.
REQ-007 tx_en  input  1  permits new frames to start when 1.
REQ-008 rinc  output  1  FIFO pop strobe.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 frame_done  output  1  one-cycle pulse in the last clk cycle of each stop bit.

Function
REQ-012 States SHALL be IDLE, START, DATA, PARITY (present only with the macro in REQ-030) and STOP.
REQ-013 Pop condition: in IDLE, at the first rising edge where tx_en=1 and rempty=0, the block SHALL:
- load rdata into the shift register
- assert rinc for exactly that one following cycle
- drive tx=0
- enter START with the bit counter cleared
REQ-014 rinc SHALL never be high for more than one consecutive cycle, and SHALL never be high while rempty=1 was sampled.
REQ-015 Each of START, every DATA bit, PARITY and STOP SHALL hold tx for exactly CLKS_PER_BIT cycles, timed by the baud counter.
REQ-016 DATA SHALL emit DSIZE bits LSB first, using a bit index that wraps from DSIZE-1 to the next state.
REQ-017 STOP SHALL drive tx=1.
REQ-018 Back-to-back frames: in the last STOP cycle, if tx_en=1 and rempty=0, the block SHALL pop per REQ-013 and go directly to START with no idle gap.
- Frame period without parity: (DSIZE+2)*CLKS_PER_BIT cycles.
REQ-019 Otherwise, the last STOP cycle SHALL transition to IDLE.
REQ-020 tx_en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-021 rdata and rempty changes after the pop SHALL NOT affect the frame in progress.
REQ-022 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide and reset to 0 at each bit boundary; no counter SHALL overflow for any legal parameter.

Reset
REQ-023 While rst_n=0, outputs SHALL be tx=1, rinc=0, busy=0, frame_done=0, and the state SHALL be IDLE.
REQ-024 While rst_n=0, the baud counter, bit index and shift register SHALL be cleared.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, asynchronously forcing tx=1; the popped word is lost.
REQ-026 After rst_n deasserts, the first pop SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-030 Macro FIFO_UART_TX_PARITY_EN defined: a PARITY state SHALL follow DATA and transmit even parity, the XOR of the DSIZE data bits.
- Frame length becomes (DSIZE+3)*CLKS_PER_BIT cycles.
REQ-031 Macro FIFO_UART_TX_PARITY_EN undefined: the PARITY state and parity logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-032 Package fifo_uart_pkg SHALL hold the state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4) and the default DSIZE/CLKS_PER_BIT values.
REQ-033 Sub-module uart_baud_gen SHALL implement the CLKS_PER_BIT counter, with a restart input and a bit_end pulse output.
REQ-034 fifo_uart_tx SHALL contain the state machine, shift register, bit index and pop logic.

Verification (CLKS_PER_BIT=4, DSIZE=8)
REQ-040 Single word: reset, FIFO preloaded with 0xA5, tx_en=1 -> one rinc pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; frame_done once 40 cycles after the pop.
REQ-041 Back-to-back: 0x01, 0x80, 0xFF queued -> 3 rinc pulses exactly 40 cycles apart, tx never idle between frames, busy continuously high.
REQ-042 Empty and gating: rempty=1 for 100 cycles -> rinc=0, tx=1, busy=0; tx_en=0 with data queued -> no pop; tx_en dropped mid-frame -> current frame completes, no next pop.
REQ-043 Reset mid-frame: rst_n low during bit 3 of 0x55 -> tx=1 and busy=0 without waiting for a clk edge; after release, the next queued word is sent cleanly.
REQ-044 Parity, with FIFO_UART_TX_PARITY_EN defined: 0x07 -> parity bit 1, frame 44 cycles; 0x03 -> parity bit 0.
REQ-045 End to end with the FIFO: write 16 words until wfull, enable the block -> a serial monitor decodes 0..15 in order, rempty asserts after the 16th pop, and there is no 17th rinc.
